imm_decode_stage: RTL

- Pipelined decode stage directly upstream of the immediate lookup table.
- Accepts 9-bit instructions from fetch over a valid/ready handshake and registers the decoded fields.
- Produces the 5-bit immediate index that drives the LUT, plus register/opcode fields for the datapath.
- Contains a 2-entry skid buffer so fetch and execute decouple without bubbles, and a halt tracker that raises done when the program ends.

---
 rtl/imm_decode_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// Decode stage feeding the immediate LUT: valid/ready intake, two-entry skid
// buffer of decoded fields, and a halt tracker that raises done after HALT drains.
module imm_decode_stage #(
    parameter int unsigned IW          = 9,
    parameter int unsigned IMM_ENTRIES = 25
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_op,
    output logic [2:0]    out_rd,
    output logic [2:0]    out_rs,
    output logic          out_is_imm,
    output logic [4:0]    out_imm_index,
    output logic          out_illegal_imm,
    output logic          done
);

    localparam int unsigned IDXW = 5;
    localparam logic [2:0]  OP_LDI = 3'b111;

    typedef struct packed {
        logic [2:0]      op;
        logic [2:0]      rd;
        logic [2:0]      rs;
        logic            is_imm;
        logic [IDXW-1:0] imm_index;
        logic            illegal;
        logic            is_halt;
    } entry_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t m_q, m_d, s_q, s_d, dec;
    logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic   ready_c, accept_c, pop_c;

    // Field decode of the incoming word; non-LDI words carry a zero LUT index.
    always_comb begin
        dec         = '0;
        dec.op      = in_instr[8:6];
        dec.is_halt = (in_instr == '0);
        if (in_instr[8:6] == OP_LDI) begin
            dec.rd        = {2'b00, in_instr[5]};
            dec.imm_index = in_instr[4:0];
            dec.is_imm    = 1'b1;
            dec.illegal   = (32'(in_instr[4:0]) >= IMM_ENTRIES);
        end else begin
            dec.rd = in_instr[5:3];
            dec.rs = in_instr[2:0];
        end
    end

    assign ready_c  = !s_valid_q && (state_q == ST_RUN);
    assign accept_c = in_valid && ready_c;
    assign pop_c    = m_valid_q && out_ready;

    // Buffer movement and halt tracking; flush overrides accept and pop.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            if (state_q == ST_HALT_PEND) begin
                state_d = ST_RUN;
            end
        end else begin
            if (pop_c && s_valid_q) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end else if (!m_valid_q || pop_c) begin
                m_valid_d = accept_c;
                if (accept_c) begin
                    m_d = dec;
                end
            end else if (accept_c) begin
                s_d       = dec;
                s_valid_d = 1'b1;
            end

            case (state_q)
                ST_RUN: begin
                    if (accept_c && dec.is_halt) begin
                        state_d = ST_HALT_PEND;
                    end
                end
                ST_HALT_PEND: begin
                    if (pop_c && m_q.is_halt) begin
                        state_d = ST_HALTED;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_RUN;
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign in_ready        = !Reset && ready_c;
    assign out_valid       = m_valid_q;
    assign out_op          = m_q.op;
    assign out_rd          = m_q.rd;
    assign out_rs          = m_q.rs;
    assign out_is_imm      = m_q.is_imm;
    assign out_imm_index   = m_q.imm_index;
    assign out_illegal_imm = m_q.illegal;
    assign done            = (state_q == ST_HALTED);

endmodule
